// File: rtl/io_write_capture.sv
// io_write_capture: snoops CPU writes that hit a 16-byte I/O window and queues
// {offset, data} entries in a small FIFO for a downstream consumer.
// A write held on the bus for several cycles is captured only once.
// Optional feature: define IOCAP_OVERFLOW_EN to report dropped writes on 'overflow'.
module io_write_capture #(
   parameter logic [7:0]  BASE_ADDR = 8'hF0,
   parameter int unsigned DEPTH     = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        MemRW,
   input  logic [7:0]  MemAddr,
   input  logic [15:0] MemD,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [3:0]  out_addr,
   output logic [15:0] out_data,
   output logic [4:0]  fifo_count,
   output logic        overflow,
   input  logic        ovf_clr
);

   localparam int unsigned   PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [4:0]    LP_DEPTH = 5'(DEPTH);
   localparam logic [PW-1:0] LP_ONE   = PW'(1);

   logic          r_prev_wr;
   logic [7:0]    r_prev_addr;
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [4:0]    r_count;
   logic [19:0]   r_mem [DEPTH];

   logic          w_hit;
   logic          w_event;
   logic          w_full;
   logic          w_pop;
   logic          w_push;
   logic [4:0]    w_count_d;
   logic [19:0]   w_head;

   assign w_hit   = MemRW && (MemAddr[7:4] == BASE_ADDR[7:4]);
   // New event only when the strobe rises or the address moves on.
   assign w_event = w_hit && (!r_prev_wr || (r_prev_addr != MemAddr));
   assign w_full  = (r_count == LP_DEPTH);
   assign w_pop   = out_valid && out_ready;
   // A pop at the same edge frees the slot, so a full FIFO still accepts.
   assign w_push  = w_event && (!w_full || w_pop);

   assign w_head     = r_mem[r_rd_ptr];
   assign out_valid  = (r_count != 5'd0);
   assign out_addr   = out_valid ? w_head[19:16] : 4'h0;
   assign out_data   = out_valid ? w_head[15:0]  : 16'h0000;
   assign fifo_count = r_count;

   // Previous-cycle bus state used for held-write filtering.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_prev_wr   <= 1'b0;
         r_prev_addr <= 8'h00;
      end else begin
         r_prev_wr   <= MemRW;
         r_prev_addr <= MemAddr;
      end
   end

   // Next occupancy from the push/pop pair.
   always_comb begin
      w_count_d = r_count;
      case ({w_push, w_pop})
         2'b10:   w_count_d = r_count + 5'd1;
         2'b01:   w_count_d = r_count - 5'd1;
         default: w_count_d = r_count;
      endcase
   end

   // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= 5'd0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + LP_ONE;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + LP_ONE;
         r_count <= w_count_d;
      end
   end

   // Entry storage; contents are only visible through the occupancy-gated head.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= {MemAddr[3:0], MemD};
   end

`ifdef IOCAP_OVERFLOW_EN
   logic w_drop;
   logic r_overflow;

   assign w_drop   = w_event && w_full && !w_pop;
   assign overflow = r_overflow;

   // Sticky drop flag; a drop at the same edge as a clear keeps it set.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_overflow <= 1'b0;
      end else if (w_drop) begin
         r_overflow <= 1'b1;
      end else if (ovf_clr) begin
         r_overflow <= 1'b0;
      end
   end
`else
   // Reporting disabled: drops are silent and ovf_clr has no function.
   assign overflow = ovf_clr & 1'b0;
`endif

endmodule

// File: tb/tb_io_write_capture.sv
// Scoreboard bench for io_write_capture: a behavioural queue model predicts
// captured entries, occupancy and the overflow flag every cycle.
module tb_io_write_capture;

   logic        clk;
   logic        rst;
   logic        MemRW;
   logic [7:0]  MemAddr;
   logic [15:0] MemD;
   logic        out_valid;
   logic        out_ready;
   logic [3:0]  out_addr;
   logic [15:0] out_data;
   logic [4:0]  fifo_count;
   logic        overflow;
   logic        ovf_clr;

   int n_vec;
   int n_err;

   logic [19:0] q[$];
   logic        m_prev_wr;
   logic [7:0]  m_prev_addr;
   logic        m_ovf;

   io_write_capture #(
      .BASE_ADDR (8'hF0),
      .DEPTH     (4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .MemRW      (MemRW),
      .MemAddr    (MemAddr),
      .MemD       (MemD),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_addr   (out_addr),
      .out_data   (out_data),
      .fifo_count (fifo_count),
      .overflow   (overflow),
      .ovf_clr    (ovf_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Check the DUT against the model, update the model for the coming edge, then clock.
   task automatic step();
      logic        ev;
      logic        full;
      logic        pop;
      logic [19:0] exp;
      ev   = MemRW && (MemAddr[7:4] == 4'hF) && (!m_prev_wr || (m_prev_addr != MemAddr));
      full = (q.size() == 4);
      pop  = (q.size() != 0) && out_ready;
      check_eq("valid", 32'(out_valid), 32'(q.size() != 0));
      check_eq("count", 32'(fifo_count), 32'(q.size()));
      check_eq("ovf", 32'(overflow), 32'(m_ovf));
      if (q.size() != 0) check_eq("head", 32'({out_addr, out_data}), 32'(q[0]));
      if (pop) exp = q.pop_front();
      if (ev && (!full || pop)) q.push_back({MemAddr[3:0], MemD});
`ifdef IOCAP_OVERFLOW_EN
      if (ev && full && !pop) m_ovf = 1'b1;
      else if (ovf_clr) m_ovf = 1'b0;
`endif
      m_prev_wr   = MemRW;
      m_prev_addr = MemAddr;
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [7:0] a, input logic [15:0] d);
      MemRW   = 1'b1;
      MemAddr = a;
      MemD    = d;
      step();
   endtask

   task automatic idle();
      MemRW   = 1'b0;
      MemAddr = 8'h00;
      MemD    = 16'h0000;
      step();
   endtask

   task automatic drain();
      out_ready = 1'b1;
      MemRW     = 1'b0;
      for (int i = 0; i < 20 && q.size() != 0; i++) step();
      check_eq("drain", 32'(q.size()), 32'd0);
      out_ready = 1'b0;
      step();
   endtask

   initial begin
      n_vec       = 0;
      n_err       = 0;
      m_prev_wr   = 1'b0;
      m_prev_addr = 8'h00;
      m_ovf       = 1'b0;
      rst         = 1'b0;
      MemRW       = 1'b0;
      MemAddr     = 8'h00;
      MemD        = 16'h0000;
      out_ready   = 1'b0;
      ovf_clr     = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_valid", 32'(out_valid), 32'd0);
      check_eq("rst_count", 32'(fifo_count), 32'd0);
      check_eq("rst_ovf", 32'(overflow), 32'd0);
      check_eq("rst_head", 32'({out_addr, out_data}), 32'd0);
      rst = 1'b1;
      step();

      // Held write is captured once.
      for (int i = 0; i < 3; i++) wr(8'hF3, 16'hBEEF);
      idle();
      check_eq("single_count", 32'(fifo_count), 32'd1);
      check_eq("single_addr", 32'(out_addr), 32'h3);
      check_eq("single_data", 32'(out_data), 32'hBEEF);
      idle();
      drain();

      // Out-of-window writes and in-window reads are ignored.
      wr(8'h20, 16'h1234);
      wr(8'h2F, 16'h5678);
      MemRW = 1'b0; MemAddr = 8'hF5; step();
      idle();
      check_eq("filter_count", 32'(fifo_count), 32'd0);
      check_eq("filter_valid", 32'(out_valid), 32'd0);

      // Fill, drop the fifth, then exercise overflow clear.
      for (int i = 0; i < 5; i++) wr(8'hF0 + 8'(i), 16'(i + 1));
      idle();
      check_eq("full_count", 32'(fifo_count), 32'd4);
`ifdef IOCAP_OVERFLOW_EN
      check_eq("full_ovf", 32'(overflow), 32'd1);
`else
      check_eq("full_ovf", 32'(overflow), 32'd0);
`endif
      ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
      idle();
      check_eq("clr_ovf", 32'(overflow), 32'd0);
      ovf_clr = 1'b1; wr(8'hF5, 16'h0055); ovf_clr = 1'b0;
      idle();
`ifdef IOCAP_OVERFLOW_EN
      check_eq("clr_drop_ovf", 32'(overflow), 32'd1);
`else
      check_eq("clr_drop_ovf", 32'(overflow), 32'd0);
`endif
      check_eq("full_head", 32'({out_addr, out_data}), 32'h00001);
      drain();

      // Push and pop at the same edge while full.
      for (int i = 0; i < 4; i++) wr(8'hF0 + 8'(i), 16'hA0 + 16'(i));
      ovf_clr = 1'b1; idle(); ovf_clr = 1'b0;
      out_ready = 1'b1; wr(8'hF7, 16'h7777); out_ready = 1'b0;
      idle();
      check_eq("pp_count", 32'(fifo_count), 32'd4);
      check_eq("pp_ovf", 32'(overflow), 32'd0);
      check_eq("pp_head", 32'({out_addr, out_data}), 32'h100A1);
      drain();

      // Reset mid-operation, with a write held across release.
      wr(8'hF0, 16'h0AA0);
      wr(8'hF2, 16'h0BB0);
      idle();
      #1 rst = 1'b0;
      #1;
      check_eq("arst_valid", 32'(out_valid), 32'd0);
      check_eq("arst_count", 32'(fifo_count), 32'd0);
      check_eq("arst_head", 32'({out_addr, out_data}), 32'd0);
      q.delete();
      m_prev_wr   = 1'b0;
      m_prev_addr = 8'h00;
      m_ovf       = 1'b0;
      MemRW = 1'b1; MemAddr = 8'hF1; MemD = 16'h1111;
      @(posedge clk);
      #1 rst = 1'b1;
      for (int i = 0; i < 3; i++) wr(8'hF1, 16'h1111);
      idle();
      check_eq("rel_count", 32'(fifo_count), 32'd1);
      check_eq("rel_head", 32'({out_addr, out_data}), 32'h11111);
      drain();

      // Random traffic with held writes, reads and back-pressure.
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 3) != 0) begin
            MemRW   = 1'($urandom_range(0, 1));
            MemAddr = ($urandom_range(0, 4) == 0) ? 8'h25 : {4'hF, 4'($urandom_range(0, 3))};
            MemD    = 16'($urandom);
         end
         out_ready = ($urandom_range(0, 2) == 0);
         ovf_clr   = ($urandom_range(0, 7) == 0);
         step();
      end
      ovf_clr = 1'b0;
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
